// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
// Module : sad_pkg
// Brief  : Shared constants, FSM state type and pixel-unpack helper for the
//          SAD minimum-search engine.
// Rev    : 1.0  initial release
// ============================================================================
package sad_pkg;

    localparam int MAX_PIX_W = 16;
    localparam int MAX_BUS_W = 16 * MAX_PIX_W;

    // Total SAD width: sixteen pixel differences need four extra bits.
    function automatic int sad_w(input int word_w);
        return word_w + 4;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Pixel idx of a 16-pixel raster bus (pixel 0 in the MSBs), zero-extended.
    function automatic logic [MAX_PIX_W-1:0] pix_unpack(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   pix_w,
        input int                   idx
    );
        logic [MAX_PIX_W-1:0] mask;
        mask = (MAX_PIX_W'(1) << pix_w) - MAX_PIX_W'(1);
        return MAX_PIX_W'(bus >> ((15 - idx) * pix_w)) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sad16_pipe.sv
`default_nettype none
// ============================================================================
// Module : sad16_pipe
// Brief  : Three-stage 4x4 SAD pipeline (abs-diff, 4-input sums, total) with
//          valid bit and tag carried alongside the data.
// Rev    : 1.0  initial release
// ============================================================================
module sad16_pipe
    import sad_pkg::*;
#(
    parameter int WORD_WIDETH = 8,
    parameter int TAG_W       = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [TAG_W-1:0]                in_tag,
    input  logic [16*WORD_WIDETH-1:0]       cur_blk,
    input  logic [16*WORD_WIDETH-1:0]       cand_blk,
    output logic                            out_valid,
    output logic [TAG_W-1:0]                out_tag,
    output logic [sad_w(WORD_WIDETH)-1:0]   out_sad
);

    localparam int PSUM_W = WORD_WIDETH + 2;
    localparam int SAD_W  = sad_w(WORD_WIDETH);

    logic [WORD_WIDETH-1:0] w_cand_pix [16];
    logic [WORD_WIDETH-1:0] w_cur_pix  [16];
    logic [WORD_WIDETH-1:0] r_ad       [16];
    logic [PSUM_W-1:0]      r_ps       [4];
    logic [SAD_W-1:0]       r_sad;
    logic                   r_v1, r_v2, r_v3;
    logic [TAG_W-1:0]       r_t1, r_t2, r_t3;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_cand_pix[i] = WORD_WIDETH'(pix_unpack(MAX_BUS_W'(cand_blk), WORD_WIDETH, i));
            w_cur_pix[i]  = WORD_WIDETH'(pix_unpack(MAX_BUS_W'(cur_blk), WORD_WIDETH, i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            r_ad[i] <= (w_cand_pix[i] > w_cur_pix[i]) ? w_cand_pix[i] - w_cur_pix[i]
                                                      : w_cur_pix[i] - w_cand_pix[i];
        end
        for (int j = 0; j < 4; j++) begin
            r_ps[j] <= PSUM_W'(r_ad[4*j])   + PSUM_W'(r_ad[4*j+1])
                     + PSUM_W'(r_ad[4*j+2]) + PSUM_W'(r_ad[4*j+3]);
        end
        r_sad <= SAD_W'(r_ps[0]) + SAD_W'(r_ps[1]) + SAD_W'(r_ps[2]) + SAD_W'(r_ps[3]);
        r_t1  <= in_tag;
        r_t2  <= r_t1;
        r_t3  <= r_t2;
    end

    // Only the valid bits need clearing; stale data behind them is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    assign out_valid = r_v3;
    assign out_tag   = r_t3;
    assign out_sad   = r_sad;

endmodule
`default_nettype wire

// File: rtl/sad_min_search.sv
`default_nettype none
// ============================================================================
// Module : sad_min_search
// Brief  : Search control FSM, candidate index counter, current-block latch
//          and strict-minimum tracker around the SAD pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module sad_min_search
    import sad_pkg::*;
#(
    parameter int WORD_WIDETH = 8,
    parameter int SR_XW       = 3,
    parameter int SR_YW       = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [16*WORD_WIDETH-1:0]       cur_blk,
    input  logic                            cand_valid,
    input  logic [16*WORD_WIDETH-1:0]       cand_blk,
    output logic                            cand_ready,
    output logic                            busy,
    output logic                            done,
    output logic [sad_w(WORD_WIDETH)-1:0]   best_sad,
    output logic [SR_XW-1:0]                best_x,
    output logic [SR_YW-1:0]                best_y
);

    localparam int              TAG_W    = SR_XW + SR_YW;
    localparam int              SAD_W    = sad_w(WORD_WIDETH);
    localparam logic [TAG_W-1:0] LAST_IDX = '1;

    state_t                     r_state, w_next;
    logic [TAG_W-1:0]           r_cnt;
    logic [16*WORD_WIDETH-1:0]  r_cur;
    logic                       w_accept, w_start_ok;
    logic                       w_pipe_valid;
    logic [TAG_W-1:0]           w_pipe_tag;
    logic [SAD_W-1:0]           w_pipe_sad;

    assign w_accept   = cand_valid && (r_state == RUN);
    assign w_start_ok = start && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        cand_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE:  if (start) w_next = RUN;
            RUN: begin
                cand_ready = 1'b1;
                busy       = 1'b1;
                if (cand_valid && (r_cnt == LAST_IDX)) w_next = DRAIN;
            end
            // Tags arrive in index order, so the last one marks an empty pipe.
            DRAIN: begin
                busy = 1'b1;
                if (w_pipe_valid && (w_pipe_tag == LAST_IDX)) w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_start_ok) r_cur <= cur_blk;
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_cnt    <= '0;
            best_sad <= '1;
            best_x   <= '0;
            best_y   <= '0;
        end else begin
            if (w_accept) r_cnt <= r_cnt + TAG_W'(1);
            // Strict compare keeps the earliest raster index on ties.
            if (w_pipe_valid && (w_pipe_sad < best_sad)) begin
                best_sad <= w_pipe_sad;
                best_x   <= w_pipe_tag[SR_XW-1:0];
                best_y   <= w_pipe_tag[TAG_W-1:SR_XW];
            end
        end
    end

    sad16_pipe #(
        .WORD_WIDETH (WORD_WIDETH),
        .TAG_W       (TAG_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_accept),
        .in_tag    (r_cnt),
        .cur_blk   (r_cur),
        .cand_blk  (cand_blk),
        .out_valid (w_pipe_valid),
        .out_tag   (w_pipe_tag),
        .out_sad   (w_pipe_sad)
    );

endmodule
`default_nettype wire
